switch_debounce: RTL



---
 rtl/debounce_pkg.sv | 9 +
 rtl/sync_2ff.sv | 21 ++
 rtl/switch_debounce.sv | 117 +++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-switch debounce filter.
package debounce_pkg;

  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} debounce_state_t;

  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;  // 10 ms at CLK_HZ
  localparam int CLK_HZ                 = 25000000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop metastability synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounce filter for one mechanical switch, with one-cycle rise/fall strobes.
// Define SWITCH_DEBOUNCE_SYNC_EN to add a two-flop synchronizer ahead of the sample register.
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (DEBOUNCE_LIMIT < 2) begin : g_limit_check
      $error("switch_debounce: DEBOUNCE_LIMIT must be >= 2");
    end
  endgenerate

  logic            sw_sync;
  logic            sw_p0;
  debounce_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            sw_nxt, rise_nxt, fall_nxt;

`ifdef SWITCH_DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .d     (i_Switch),
    .q     (sw_sync)
  );
`else
  assign sw_sync = i_Switch;
`endif

  // Stage p0: sampled switch level
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) sw_p0 <= 1'b0;
    else          sw_p0 <= sw_sync;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sw_p0) begin
          state_nxt = PEND_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      PEND_HI: begin
        if (!sw_p0) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sw_p0) begin
          state_nxt = PEND_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      PEND_LO: begin
        if (sw_p0) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
    // Pending states still report the old stable level
    sw_nxt = (state_nxt == STABLE_HI) || (state_nxt == PEND_LO);
  end

  // Stage p1: filter state and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state    <= STABLE_LO;
      cnt      <= '0;
      o_Switch <= 1'b0;
      o_Rise   <= 1'b0;
      o_Fall   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      o_Switch <= sw_nxt;
      o_Rise   <= rise_nxt;
      o_Fall   <= fall_nxt;
    end
  end

endmodule
